// File: rtl/iob2axil_pkg.sv
// -----------------------------------------------------------------------------
// iob2axil_pkg
// Shared definitions for the IOb-native to AXI4-Lite bridge:
//   - AXI4-Lite field widths and the OKAY response code
//   - bridge FSM state encoding (3 bits)
//   - small helper that classifies an AXI response as an error
// No ports (package).
// -----------------------------------------------------------------------------
package iob2axil_pkg;

  localparam int AXI_PROT_W = 3;
  localparam int AXI_RESP_W = 2;

  localparam logic [AXI_RESP_W-1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    W_RESP  = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    DONE    = 3'd5
  } state_t;

  // Any response other than OKAY (EXOKAY is not legal on AXI4-Lite) is an error.
  function automatic logic resp_is_err(input logic [AXI_RESP_W-1:0] resp);
    return (resp != AXI_RESP_OKAY);
  endfunction

endpackage

// File: rtl/iob2axil_if.sv
// -----------------------------------------------------------------------------
// Bus interfaces used by iob2axil.
//
// iob_if  : IOb native bus.
//   master drives valid/addr/wdata/wstrb, slave returns rdata/ready/err.
//   wstrb == 0 means read. ready is a single-cycle completion pulse and err
//   is meaningful only while ready is high.
//
// axil_if : AXI4-Lite bus (AW, W, B, AR, R channels).
//   master drives the address/data valids and bready/rready, slave drives the
//   corresponding readies, bresp/bvalid and rdata/rresp/rvalid.
// -----------------------------------------------------------------------------
interface iob_if #(
  parameter int AXIL_ADDR_W = 32,
  parameter int AXIL_DATA_W = 32
) ();

  logic                     valid;
  logic [AXIL_ADDR_W-1:0]   addr;
  logic [AXIL_DATA_W-1:0]   wdata;
  logic [AXIL_DATA_W/8-1:0] wstrb;
  logic [AXIL_DATA_W-1:0]   rdata;
  logic                     ready;
  logic                     err;

  modport master (
    output valid, addr, wdata, wstrb,
    input  rdata, ready, err
  );

  modport slave (
    input  valid, addr, wdata, wstrb,
    output rdata, ready, err
  );

endinterface

interface axil_if #(
  parameter int AXIL_ADDR_W = 32,
  parameter int AXIL_DATA_W = 32
) ();

  import iob2axil_pkg::*;

  // write address channel
  logic [AXIL_ADDR_W-1:0]   awaddr;
  logic [AXI_PROT_W-1:0]    awprot;
  logic                     awvalid;
  logic                     awready;
  // write data channel
  logic [AXIL_DATA_W-1:0]   wdata;
  logic [AXIL_DATA_W/8-1:0] wstrb;
  logic                     wvalid;
  logic                     wready;
  // write response channel
  logic [AXI_RESP_W-1:0]    bresp;
  logic                     bvalid;
  logic                     bready;
  // read address channel
  logic [AXIL_ADDR_W-1:0]   araddr;
  logic [AXI_PROT_W-1:0]    arprot;
  logic                     arvalid;
  logic                     arready;
  // read data channel
  logic [AXIL_DATA_W-1:0]   rdata;
  logic [AXI_RESP_W-1:0]    rresp;
  logic                     rvalid;
  logic                     rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid,    input wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid,    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input rready
  );

endinterface

// File: rtl/iob2axil.sv
// -----------------------------------------------------------------------------
// iob2axil
// Bridges an IOb native slave port onto an AXI4-Lite master port. One
// transaction is in flight at a time; a request with nonzero wstrb becomes an
// AXI write, otherwise an AXI read. Every output (native and AXI) comes
// straight from a flop.
//
// Ports:
//   clk     : clock
//   rst     : synchronous, active-high reset (abandons any AXI transaction)
//   iob_s   : IOb native bus, slave side (valid/addr/wdata/wstrb in,
//             rdata/ready/err out)
//   axil_m  : AXI4-Lite bus, master side (AW/W/AR valids, bready, rready out)
// -----------------------------------------------------------------------------
module iob2axil
  import iob2axil_pkg::*;
#(
  parameter int AXIL_ADDR_W = 32,
  parameter int AXIL_DATA_W = 32
) (
  input  logic   clk,
  input  logic   rst,
  iob_if.slave   iob_s,
  axil_if.master axil_m
);

  localparam int STRB_W = AXIL_DATA_W / 8;

  // FSM state
  state_t state_q, state_d;

  // Request captured in IDLE; the native master may change its inputs later.
  logic [AXIL_ADDR_W-1:0] addr_q,  addr_d;
  logic [AXIL_DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]      wstrb_q, wstrb_d;

  // AXI handshake outputs
  logic awvalid_q, awvalid_d;
  logic wvalid_q,  wvalid_d;
  logic bready_q,  bready_d;
  logic arvalid_q, arvalid_d;
  logic rready_q,  rready_d;

  // Per-channel completion flags for the write address/data channels
  logic aw_done_q, aw_done_d;
  logic w_done_q,  w_done_d;

  // Native response outputs
  logic                   ready_q, ready_d;
  logic                   err_q,   err_d;
  logic [AXIL_DATA_W-1:0] rdata_q, rdata_d;

  // A channel counts as done if it finished earlier or handshakes this cycle,
  // so AW and W may complete in either order or together.
  logic aw_done_s;
  logic w_done_s;

  assign aw_done_s = aw_done_q | (awvalid_q & axil_m.awready);
  assign w_done_s  = w_done_q  | (wvalid_q  & axil_m.wready);

  // State and datapath registers, cleared by the synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= {AXIL_ADDR_W{1'b0}};
      wdata_q   <= {AXIL_DATA_W{1'b0}};
      wstrb_q   <= {STRB_W{1'b0}};
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= {AXIL_DATA_W{1'b0}};
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  // Next-state and next-output logic of the bridge FSM
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    ready_d   = 1'b0;      // ready is a one-cycle pulse
    err_d     = err_q;
    rdata_d   = rdata_q;

    case (state_q)
      IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (iob_s.valid) begin
          addr_d  = iob_s.addr;
          wdata_d = iob_s.wdata;
          wstrb_d = iob_s.wstrb;
          if (iob_s.wstrb != {STRB_W{1'b0}}) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WRITE;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end else begin
          state_d = IDLE;
        end
      end

      WRITE: begin
        // Each valid falls on the cycle after its own handshake.
        awvalid_d = awvalid_q & ~axil_m.awready;
        wvalid_d  = wvalid_q  & ~axil_m.wready;
        aw_done_d = aw_done_s;
        w_done_d  = w_done_s;
        if (aw_done_s && w_done_s) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          bready_d  = 1'b1;
          state_d   = W_RESP;
        end else begin
          state_d = WRITE;
        end
      end

      W_RESP: begin
        if (axil_m.bvalid) begin
          bready_d = 1'b0;
          err_d    = resp_is_err(axil_m.bresp);
          ready_d  = 1'b1;
          state_d  = DONE;
        end else begin
          state_d = W_RESP;
        end
      end

      RD_ADDR: begin
        if (axil_m.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end else begin
          state_d = RD_ADDR;
        end
      end

      RD_DATA: begin
        if (axil_m.rvalid) begin
          rready_d = 1'b0;
          rdata_d  = axil_m.rdata;
          err_d    = resp_is_err(axil_m.rresp);
          ready_d  = 1'b1;
          state_d  = DONE;
        end else begin
          state_d = RD_DATA;
        end
      end

      DONE: begin
        // ready is high this cycle; valid is not looked at so a master that
        // still holds valid cannot start a second transaction.
        err_d   = 1'b0;
        state_d = IDLE;
      end

      default: begin
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        err_d     = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // Native side outputs
  assign iob_s.rdata = rdata_q;
  assign iob_s.ready = ready_q;
  assign iob_s.err   = err_q;

  // AXI side outputs; address and data come from the captured request
  assign axil_m.awaddr  = addr_q;
  assign axil_m.awprot  = {AXI_PROT_W{1'b0}};
  assign axil_m.awvalid = awvalid_q;
  assign axil_m.wdata   = wdata_q;
  assign axil_m.wstrb   = wstrb_q;
  assign axil_m.wvalid  = wvalid_q;
  assign axil_m.bready  = bready_q;
  assign axil_m.araddr  = addr_q;
  assign axil_m.arprot  = {AXI_PROT_W{1'b0}};
  assign axil_m.arvalid = arvalid_q;
  assign axil_m.rready  = rready_q;

endmodule

// File: tb/tb_iob2axil.sv
// -----------------------------------------------------------------------------
// tb_iob2axil
// Table-driven bench for iob2axil. Each vector describes one native request,
// the AXI slave latencies/response to use, and the hand-computed completion
// cycle, err and rdata. A behavioural AXI slave inside run_vec responds at
// the negative clock edge. A hand-written sequence covers reset in mid-write.
// -----------------------------------------------------------------------------
module tb_iob2axil;
  import iob2axil_pkg::*;

  logic clk;
  logic rst;

  iob_if  #(.AXIL_ADDR_W(32), .AXIL_DATA_W(32)) iob_bus ();
  axil_if #(.AXIL_ADDR_W(32), .AXIL_DATA_W(32)) axil_bus ();

  iob2axil #(.AXIL_ADDR_W(32), .AXIL_DATA_W(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .iob_s  (iob_bus),
    .axil_m (axil_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_dly;
    int          w_dly;
    int          b_dly;
    int          ar_dly;
    int          r_dly;
    logic [1:0]  resp;
    logic [31:0] slv_rdata;
    logic        scramble;   // change/drop native inputs mid-transaction
    int          exp_cyc;    // cycle in which ready is expected
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One native transaction against a behavioural AXI slave, then checks.
  task automatic run_vec(input int idx, input vec_t v);
    int aw_hs, w_hs, b_hs, ar_hs, r_hs;
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;
    int ready_cnt, ready_cyc, extra_axi, early_b, data_bad, err_after;
    logic        err_at;
    logic [31:0] rdata_at;
    logic        is_wr;
    aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
    aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
    ready_cnt = 0; ready_cyc = 0; extra_axi = 0; early_b = 0;
    data_bad = 0; err_after = 0; err_at = 1'b0; rdata_at = 32'h0;
    is_wr = (v.wstrb != 4'h0);

    iob_bus.valid = 1'b1;
    iob_bus.addr  = v.addr;
    iob_bus.wdata = v.wdata;
    iob_bus.wstrb = v.wstrb;

    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (iob_bus.ready) begin
        ready_cnt++;
        if (ready_cyc == 0) begin
          ready_cyc = c;
          err_at    = iob_bus.err;
          rdata_at  = iob_bus.rdata;
        end
      end
      if (ready_cyc != 0 && c == ready_cyc + 1) begin
        iob_bus.valid = 1'b0;
        if (iob_bus.err !== 1'b0) err_after++;
      end
      if (v.scramble && c == 2) begin
        iob_bus.valid = 1'b0;
        iob_bus.addr  = ~v.addr;
        iob_bus.wdata = ~v.wdata;
        iob_bus.wstrb = 4'h0;
      end
      if (ready_cyc != 0 && (axil_bus.awvalid || axil_bus.wvalid || axil_bus.arvalid ||
                             axil_bus.bready || axil_bus.rready)) extra_axi++;
      // AW channel
      if (axil_bus.awvalid) begin
        axil_bus.awready = (aw_wait >= v.aw_dly);
        aw_wait++;
        if (axil_bus.awready) begin
          aw_hs++;
          if (axil_bus.awaddr !== v.addr || axil_bus.awprot !== 3'b000) data_bad++;
        end
      end else begin
        axil_bus.awready = 1'b0;
      end
      // W channel
      if (axil_bus.wvalid) begin
        axil_bus.wready = (w_wait >= v.w_dly);
        w_wait++;
        if (axil_bus.wready) begin
          w_hs++;
          if (axil_bus.wdata !== v.wdata || axil_bus.wstrb !== v.wstrb) data_bad++;
        end
      end else begin
        axil_bus.wready = 1'b0;
      end
      // B channel
      if (axil_bus.bready) begin
        if (aw_hs == 0 || w_hs == 0) early_b++;
        axil_bus.bvalid = (b_wait >= v.b_dly);
        axil_bus.bresp  = v.resp;
        b_wait++;
        if (axil_bus.bvalid) b_hs++;
      end else begin
        axil_bus.bvalid = 1'b0;
        axil_bus.bresp  = 2'b00;
      end
      // AR channel
      if (axil_bus.arvalid) begin
        axil_bus.arready = (ar_wait >= v.ar_dly);
        ar_wait++;
        if (axil_bus.arready) begin
          ar_hs++;
          if (axil_bus.araddr !== v.addr || axil_bus.arprot !== 3'b000) data_bad++;
        end
      end else begin
        axil_bus.arready = 1'b0;
      end
      // R channel
      if (axil_bus.rready) begin
        axil_bus.rvalid = (r_wait >= v.r_dly);
        axil_bus.rdata  = v.slv_rdata;
        axil_bus.rresp  = v.resp;
        r_wait++;
        if (axil_bus.rvalid) r_hs++;
      end else begin
        axil_bus.rvalid = 1'b0;
        axil_bus.rdata  = 32'h0;
        axil_bus.rresp  = 2'b00;
      end
      if (ready_cyc != 0 && c >= ready_cyc + 3) break;
    end
    iob_bus.valid = 1'b0;

    check($sformatf("v%0d_ready_count", idx), ready_cnt, 1);
    check($sformatf("v%0d_ready_cycle", idx), ready_cyc, v.exp_cyc);
    check($sformatf("v%0d_err", idx), {31'h0, err_at}, {31'h0, v.exp_err});
    check($sformatf("v%0d_rdata", idx), rdata_at, v.exp_rdata);
    check($sformatf("v%0d_aw_handshakes", idx), aw_hs, is_wr ? 1 : 0);
    check($sformatf("v%0d_w_handshakes", idx), w_hs, is_wr ? 1 : 0);
    check($sformatf("v%0d_b_handshakes", idx), b_hs, is_wr ? 1 : 0);
    check($sformatf("v%0d_ar_handshakes", idx), ar_hs, is_wr ? 0 : 1);
    check($sformatf("v%0d_r_handshakes", idx), r_hs, is_wr ? 0 : 1);
    check($sformatf("v%0d_bready_early", idx), early_b, 0);
    check($sformatf("v%0d_axi_payload", idx), data_bad, 0);
    check($sformatf("v%0d_axi_after_done", idx), extra_axi, 0);
    check($sformatf("v%0d_err_cleared", idx), err_after, 0);
  endtask

  initial begin
    //          addr      wdata         strb  aw w  b  ar r  resp   slv_rdata     scr  cyc err   exp_rdata
    vecs[0]  = '{32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0,        1'b0, 3, 1'b0, 32'h0};
    vecs[1]  = '{32'h20, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 32'h12345678, 1'b0, 3, 1'b0, 32'h12345678};
    vecs[2]  = '{32'h24, 32'hCAFEF00D, 4'h3, 3, 0, 0, 0, 0, 2'b00, 32'h0,        1'b0, 6, 1'b0, 32'h12345678};
    vecs[3]  = '{32'h28, 32'h0BADF00D, 4'hC, 0, 3, 0, 0, 0, 2'b00, 32'h0,        1'b0, 6, 1'b0, 32'h12345678};
    vecs[4]  = '{32'h2C, 32'h00000055, 4'h1, 0, 0, 0, 0, 0, 2'b10, 32'h0,        1'b0, 3, 1'b1, 32'h12345678};
    vecs[5]  = '{32'h30, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b11, 32'hA5A5A5A5, 1'b0, 3, 1'b1, 32'hA5A5A5A5};
    vecs[6]  = '{32'h34, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 32'h5A5A0001, 1'b0, 3, 1'b0, 32'h5A5A0001};
    vecs[7]  = '{32'h40, 32'h0,        4'h0, 0, 0, 0, 5, 4, 2'b00, 32'h0F0F0F0F, 1'b0, 12, 1'b0, 32'h0F0F0F0F};
    vecs[8]  = '{32'h44, 32'h11223344, 4'hF, 1, 1, 2, 0, 0, 2'b00, 32'h0,        1'b0, 6, 1'b0, 32'h0F0F0F0F};
    vecs[9]  = '{32'h48, 32'h99887766, 4'h6, 2, 0, 0, 0, 0, 2'b00, 32'h0,        1'b1, 5, 1'b0, 32'h0F0F0F0F};
    vecs[10] = '{32'h60, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 32'h600DF00D, 1'b0, 3, 1'b0, 32'h600DF00D};

    rst = 1'b1;
    iob_bus.valid = 1'b0; iob_bus.addr = 32'h0; iob_bus.wdata = 32'h0; iob_bus.wstrb = 4'h0;
    axil_bus.awready = 1'b0; axil_bus.wready = 1'b0;
    axil_bus.bvalid = 1'b0; axil_bus.bresp = 2'b00;
    axil_bus.arready = 1'b0;
    axil_bus.rvalid = 1'b0; axil_bus.rdata = 32'h0; axil_bus.rresp = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("reset_handshakes", {25'h0, axil_bus.awvalid, axil_bus.wvalid, axil_bus.arvalid,
          axil_bus.bready, axil_bus.rready, iob_bus.ready, iob_bus.err}, 32'h0);
    check("reset_rdata", iob_bus.rdata, 32'h0);
    check("reset_addr", axil_bus.awaddr, 32'h0);
    check("reset_state", {29'h0, dut.state_q}, {29'h0, IDLE});

    for (int i = 0; i < 10; i++) begin
      run_vec(i, vecs[i]);
    end

    // Reset in the middle of a write: W completes, AW is held off, then rst.
    iob_bus.valid = 1'b1; iob_bus.addr = 32'h50; iob_bus.wdata = 32'h11112222; iob_bus.wstrb = 4'hF;
    axil_bus.awready = 1'b0; axil_bus.wready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_wr_awvalid_c1", {31'h0, axil_bus.awvalid}, 32'h1);
    axil_bus.wready = 1'b1;
    iob_bus.valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_wr_valids_c2", {30'h0, axil_bus.awvalid, axil_bus.wvalid}, 32'h2);
    axil_bus.wready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid_wr_reset_handshakes", {25'h0, axil_bus.awvalid, axil_bus.wvalid, axil_bus.arvalid,
          axil_bus.bready, axil_bus.rready, iob_bus.ready, iob_bus.err}, 32'h0);
    check("mid_wr_reset_state", {29'h0, dut.state_q}, {29'h0, IDLE});
    check("mid_wr_reset_rdata", iob_bus.rdata, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("mid_wr_idle_after", {29'h0, axil_bus.awvalid, axil_bus.arvalid, iob_bus.ready}, 32'h0);

    run_vec(10, vecs[10]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
